// File: rtl/sdpb_line_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : sdpb_line_writer_if
// Description : Pixel-stream, BRAM port-A and line-publish signals of the
//               SDPB line writer. Optional drop_count under
//               SDPB_WRITER_DROP_COUNT_EN.
// Revision    : 1.0
// ============================================================================
interface sdpb_line_writer_if #(
   parameter int ADDRESS_DEPTH_A = 512,
   parameter int DATA_WIDTH_A    = 32,
   parameter int PIXEL_WIDTH     = 8
);
   localparam int c_aw = $clog2(ADDRESS_DEPTH_A);

   logic                    pix_valid;
   logic [PIXEL_WIDTH-1:0]  pix_data;
   logic                    frame_start;
   logic                    line_end;
   logic                    bank_done;
   logic                    cea;
   logic [c_aw-1:0]         ada;
   logic [DATA_WIDTH_A-1:0] din;
   logic                    line_ready;
   logic                    line_bank;
   logic [c_aw-1:0]         line_words;
   logic                    overflow;
`ifdef SDPB_WRITER_DROP_COUNT_EN
   logic [15:0]             drop_count;

   modport master (
      output pix_valid, pix_data, frame_start, line_end, bank_done,
      input  cea, ada, din, line_ready, line_bank, line_words, overflow, drop_count
   );
   modport slave (
      input  pix_valid, pix_data, frame_start, line_end, bank_done,
      output cea, ada, din, line_ready, line_bank, line_words, overflow, drop_count
   );
`else
   modport master (
      output pix_valid, pix_data, frame_start, line_end, bank_done,
      input  cea, ada, din, line_ready, line_bank, line_words, overflow
   );
   modport slave (
      input  pix_valid, pix_data, frame_start, line_end, bank_done,
      output cea, ada, din, line_ready, line_bank, line_words, overflow
   );
`endif
endinterface
`default_nettype wire

// File: rtl/sdpb_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : sdpb_line_writer
// Description : Packs pixels into BRAM words, ping-pongs two banks and
//               publishes lines. SDPB_WRITER_DROP_COUNT_EN adds drop_count.
// Revision    : 1.0
// ============================================================================
module sdpb_line_writer #(
   parameter int ADDRESS_DEPTH_A = 512,
   parameter int DATA_WIDTH_A    = 32,
   parameter int PIXEL_WIDTH     = 8
) (
   input  logic              clk,
   input  logic              resetn,
   sdpb_line_writer_if.slave bus
);
   localparam int c_aw         = $clog2(ADDRESS_DEPTH_A);
   localparam int c_ppw        = DATA_WIDTH_A / PIXEL_WIDTH;
   localparam int c_cw         = (c_ppw > 1) ? $clog2(c_ppw) : 1;
   localparam int c_bank_words = ADDRESS_DEPTH_A / 2;

   typedef enum logic [1:0] {
      S_FILL      = 2'd0,
      S_FLUSH     = 2'd1,
      S_PUBLISH   = 2'd2,
      S_WAIT_FREE = 2'd3
   } state_t;

   state_t                  r_state, w_state;
   logic                    r_wr_bank, w_wr_bank;
   logic [c_aw-1:0]         r_word_ptr, w_word_ptr;
   logic [c_cw-1:0]         r_pack_cnt, w_pack_cnt;
   logic [DATA_WIDTH_A-1:0] r_pack, w_pack;
   logic [1:0]              r_busy, w_busy;
   logic                    r_oldest, w_oldest;
   logic                    r_cea, w_cea;
   logic [c_aw-1:0]         r_ada, w_ada;
   logic [DATA_WIDTH_A-1:0] r_din, w_din;
   logic                    r_line_ready, w_line_ready;
   logic                    r_line_bank, w_line_bank;
   logic [c_aw-1:0]         r_line_words, w_line_words;
   logic                    r_overflow, w_overflow;
   logic                    w_accept, w_drop;
`ifdef SDPB_WRITER_DROP_COUNT_EN
   logic [15:0]             r_drop_count, w_drop_count;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_FILL;
         r_wr_bank    <= 1'b0;
         r_word_ptr   <= '0;
         r_pack_cnt   <= '0;
         r_pack       <= '0;
         r_busy       <= 2'b00;
         r_oldest     <= 1'b0;
         r_cea        <= 1'b0;
         r_ada        <= '0;
         r_din        <= '0;
         r_line_ready <= 1'b0;
         r_line_bank  <= 1'b0;
         r_line_words <= '0;
         r_overflow   <= 1'b0;
`ifdef SDPB_WRITER_DROP_COUNT_EN
         r_drop_count <= '0;
`endif
      end else begin
         r_state      <= w_state;
         r_wr_bank    <= w_wr_bank;
         r_word_ptr   <= w_word_ptr;
         r_pack_cnt   <= w_pack_cnt;
         r_pack       <= w_pack;
         r_busy       <= w_busy;
         r_oldest     <= w_oldest;
         r_cea        <= w_cea;
         r_ada        <= w_ada;
         r_din        <= w_din;
         r_line_ready <= w_line_ready;
         r_line_bank  <= w_line_bank;
         r_line_words <= w_line_words;
         r_overflow   <= w_overflow;
`ifdef SDPB_WRITER_DROP_COUNT_EN
         r_drop_count <= w_drop_count;
`endif
      end
   end

   always_comb begin
      w_state      = r_state;
      w_wr_bank    = r_wr_bank;
      w_word_ptr   = r_word_ptr;
      w_pack_cnt   = r_pack_cnt;
      w_pack       = r_pack;
      w_busy       = r_busy;
      w_oldest     = r_oldest;
      w_cea        = 1'b0;
      w_ada        = r_ada;
      w_din        = r_din;
      w_line_ready = 1'b0;
      w_line_bank  = r_line_bank;
      w_line_words = r_line_words;
      w_overflow   = r_overflow;
      w_accept     = 1'b0;
      w_drop       = 1'b0;
`ifdef SDPB_WRITER_DROP_COUNT_EN
      w_drop_count = r_drop_count;
`endif

      // Release is applied before any publish/wait decision in the same cycle.
      if (bus.bank_done && r_busy[r_oldest]) begin
         w_busy[r_oldest] = 1'b0;
         w_oldest         = ~r_oldest;
      end

      if (bus.frame_start) begin
         w_word_ptr = '0;
         w_pack_cnt = '0;
         w_pack     = '0;
         w_overflow = 1'b0;
`ifdef SDPB_WRITER_DROP_COUNT_EN
         w_drop_count = '0;
`endif
         if (!w_busy[r_wr_bank]) begin
            w_state  = S_FILL;
            w_accept = bus.pix_valid;
         end else begin
            w_state = S_WAIT_FREE;
            w_drop  = bus.pix_valid;
         end
      end else begin
         case (r_state)
            S_FILL: begin
               w_accept = bus.pix_valid;
               if (bus.line_end) w_state = S_FLUSH;
            end
            S_FLUSH: begin
               w_drop = bus.pix_valid;
               if (r_pack_cnt != '0) begin
                  w_cea      = 1'b1;
                  w_ada      = {r_wr_bank, r_word_ptr[c_aw-2:0]};
                  w_din      = r_pack;
                  w_word_ptr = r_word_ptr + c_aw'(1);
               end
               w_pack_cnt = '0;
               w_pack     = '0;
               w_state    = S_PUBLISH;
            end
            S_PUBLISH: begin
               w_drop       = bus.pix_valid;
               w_line_ready = 1'b1;
               w_line_bank  = r_wr_bank;
               w_line_words = r_word_ptr;
               if (w_busy == 2'b00) w_oldest = r_wr_bank;
               w_busy[r_wr_bank] = 1'b1;
               w_wr_bank  = ~r_wr_bank;
               w_word_ptr = '0;
               w_pack_cnt = '0;
               w_pack     = '0;
               w_state    = w_busy[~r_wr_bank] ? S_WAIT_FREE : S_FILL;
            end
            default: begin
               w_drop = bus.pix_valid;
               if (!w_busy[r_wr_bank]) w_state = S_FILL;
            end
         endcase
      end

      if (w_accept) begin
         if (w_word_ptr == c_aw'(c_bank_words)) begin
            w_drop = 1'b1;
         end else begin
            w_pack = w_pack | (DATA_WIDTH_A'(bus.pix_data) << (w_pack_cnt * PIXEL_WIDTH));
            if (w_pack_cnt == c_cw'(c_ppw - 1)) begin
               w_cea      = 1'b1;
               w_ada      = {r_wr_bank, w_word_ptr[c_aw-2:0]};
               w_din      = w_pack;
               w_word_ptr = w_word_ptr + c_aw'(1);
               w_pack_cnt = '0;
               w_pack     = '0;
            end else begin
               w_pack_cnt = w_pack_cnt + c_cw'(1);
            end
         end
      end

      if (w_drop) begin
         w_overflow = 1'b1;
`ifdef SDPB_WRITER_DROP_COUNT_EN
         if (w_drop_count != 16'hFFFF) w_drop_count = w_drop_count + 16'd1;
`endif
      end
   end

   assign bus.cea        = r_cea;
   assign bus.ada        = r_ada;
   assign bus.din        = r_din;
   assign bus.line_ready = r_line_ready;
   assign bus.line_bank  = r_line_bank;
   assign bus.line_words = r_line_words;
   assign bus.overflow   = r_overflow;
`ifdef SDPB_WRITER_DROP_COUNT_EN
   assign bus.drop_count = r_drop_count;
`endif
endmodule
`default_nettype wire
